// File: rtl/lca_pkg.sv
// ---------------------------------------------------------------------------
// lca_pkg
// Shared constants and types for the LM/SM multi-register sequencer.
//   OPC_LM / OPC_SM : opcodes of load-multiple / store-multiple
//   OPC_W           : width of the opcode field at the top of the instruction
//   BASE_HI/BASE_LO : base-register field, left untouched in micro-ops
//   NOP_IR          : 16-bit no-op instruction (opcode in [15:12])
//   state_e         : sequencer states
// ---------------------------------------------------------------------------
package lca_pkg;

  localparam int OPC_W   = 4;
  localparam int BASE_HI = 11;
  localparam int BASE_LO = 9;

  localparam logic [3:0]  OPC_LM = 4'b0110;
  localparam logic [3:0]  OPC_SM = 4'b0111;
  localparam logic [15:0] NOP_IR = 16'hF000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_e;

  function automatic logic is_multi(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LM) || (opc == OPC_SM);
  endfunction

endpackage

// File: rtl/lca_lowest_set.sv
// ---------------------------------------------------------------------------
// lca_lowest_set
// Find-first-set from the LSB side.
//   W     : vector width
//   IDX_W : index width
// Ports:
//   vec   : input vector
//   idx   : index of the lowest set bit (0 when none set)
//   found : 1 when at least one bit of vec is set
// ---------------------------------------------------------------------------
module lca_lowest_set #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the last hit (lowest index) wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lca_multi_seq.sv
// ---------------------------------------------------------------------------
// lca_multi_seq
// Expands an LM/SM instruction sitting in the ID stage into one micro-op per
// set bit of its register mask, lowest register first. The first micro-op is
// issued combinationally in the cycle the instruction is decoded; the rest
// follow from the remaining-mask register while the PC/IF-ID is frozen.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   id_ir, id_valid : instruction in IF/ID and its valid flag
//   stall_in        : downstream stall, freezes sequencing
//   flush           : IF/ID flush, abandons any sequence
//   busy            : a micro-op beyond the first is being issued
//   pc_write        : PC and IF/ID may advance
//   ir_load_mux     : ID stage takes new_ir instead of id_ir
//   new_ir          : generated micro-op
//   first_multiple  : current micro-op is the first of its sequence
//   reg_addr        : register index of the current micro-op
//   last_xfer       : current micro-op is the last of its sequence
//
// Build option: LCA_MULTI_ZERO_MASK_NOP_EN -- when defined, an LM/SM with an
// all-zero mask is replaced by a single NOP; otherwise it passes through.
// ---------------------------------------------------------------------------
module lca_multi_seq
  import lca_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] id_ir,
  input  logic              id_valid,
  input  logic              stall_in,
  input  logic              flush,
  output logic              busy,
  output logic              pc_write,
  output logic              ir_load_mux,
  output logic [DATA_W-1:0] new_ir,
  output logic              first_multiple,
  output logic [REG_AW-1:0] reg_addr,
  output logic              last_xfer
);

  state_e              state, state_nxt;
  logic [NUM_REGS-1:0] rem, rem_nxt;
  logic [NUM_REGS-1:0] scan, onehot, cleared;
  logic [REG_AW-1:0]   low_idx;
  logic                low_found;
  logic                multi_op;
  logic                single;
  logic [DATA_W-1:0]   micro_ir;

`ifdef LCA_MULTI_ZERO_MASK_NOP_EN
  // Keep the NOP opcode aligned to the top of the instruction for any width.
  localparam logic [DATA_W-1:0] NOP_WORD =
    {NOP_IR[15:12], {(DATA_W-OPC_W){1'b0}}};
`endif

  assign multi_op = id_valid && is_multi(id_ir[DATA_W-1 -: OPC_W]);

  // One priority encoder serves both states: the fresh mask in IDLE, the
  // remaining mask in SEQ.
  assign scan = (state == ST_SEQ) ? rem : id_ir[NUM_REGS-1:0];

  lca_lowest_set #(
    .W     (NUM_REGS),
    .IDX_W (REG_AW)
  ) u_lowest (
    .vec   (scan),
    .idx   (low_idx),
    .found (low_found)
  );

  assign onehot   = {{(NUM_REGS-1){1'b0}}, 1'b1} << low_idx;
  assign cleared  = scan & ~onehot;
  assign single   = ~|cleared;
  assign micro_ir = {id_ir[DATA_W-1:NUM_REGS], onehot};

  always_comb begin
    busy           = 1'b0;
    pc_write       = 1'b1;
    ir_load_mux    = 1'b0;
    new_ir         = '0;
    first_multiple = 1'b0;
    reg_addr       = '0;
    last_xfer      = 1'b0;
    state_nxt      = state;
    rem_nxt        = rem;

    // While reset is held the outputs show their reset values.
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (multi_op) begin
            if (low_found) begin
              ir_load_mux    = 1'b1;
              first_multiple = 1'b1;
              reg_addr       = low_idx;
              new_ir         = micro_ir;
              if (single) begin
                last_xfer = 1'b1;
              end else begin
                pc_write  = 1'b0;
                state_nxt = ST_SEQ;
                rem_nxt   = cleared;
              end
            end else begin
`ifdef LCA_MULTI_ZERO_MASK_NOP_EN
              ir_load_mux = 1'b1;
              new_ir      = NOP_WORD;
              last_xfer   = 1'b1;
`endif
            end
          end
        end
        ST_SEQ: begin
          // rem is never zero here: entry requires two or more set bits and
          // the last one sends the state back to IDLE.
          busy        = 1'b1;
          ir_load_mux = 1'b1;
          reg_addr    = low_idx;
          new_ir      = micro_ir;
          pc_write    = 1'b0;
          rem_nxt     = cleared;
          if (single) begin
            last_xfer = 1'b1;
            pc_write  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          rem_nxt   = '0;
        end
      endcase

      if (stall_in) begin
        pc_write  = 1'b0;
        state_nxt = state;
        rem_nxt   = rem;
      end

      // Flush wins over stall: the instruction being expanded is discarded.
      if (flush) begin
        state_nxt = ST_IDLE;
        rem_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_lca_multi_seq.sv
// ---------------------------------------------------------------------------
// tb_lca_multi_seq
// Drives an 8-register and a 4-register sequencer with a shared control
// stream and separate instruction streams. A reference model keeps the list
// of register indices still owed for the current LM/SM; per cycle it
// produces the expected outputs, which a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_lca_multi_seq;
  import lca_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        pcw;
    logic        irl;
    logic [15:0] nir;
    logic        fm;
    logic [2:0]  ra;
    logic        lx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] ir_a = '0, ir_b = '0;
  logic        v_a = 1'b0, v_b = 1'b0;

  logic        busy_a, pcw_a, irl_a, fm_a, lx_a;
  logic [15:0] nir_a;
  logic [2:0]  ra_a;
  logic        busy_b, pcw_b, irl_b, fm_b, lx_b;
  logic [15:0] nir_b;
  logic [1:0]  ra_b;

  lca_multi_seq #(.DATA_W(16), .NUM_REGS(8)) u_dut8 (
    .clk(clk), .reset(reset), .id_ir(ir_a), .id_valid(v_a),
    .stall_in(stall_in), .flush(flush), .busy(busy_a), .pc_write(pcw_a),
    .ir_load_mux(irl_a), .new_ir(nir_a), .first_multiple(fm_a),
    .reg_addr(ra_a), .last_xfer(lx_a)
  );

  lca_multi_seq #(.DATA_W(16), .NUM_REGS(4)) u_dut4 (
    .clk(clk), .reset(reset), .id_ir(ir_b), .id_valid(v_b),
    .stall_in(stall_in), .flush(flush), .busy(busy_b), .pc_write(pcw_b),
    .ir_load_mux(irl_b), .new_ir(nir_b), .first_multiple(fm_b),
    .reg_addr(ra_b), .last_xfer(lx_b)
  );

  always #5 clk = ~clk;

  int          pend_a[$], pend_b[$];
  exp_t        exp_a[$], exp_b[$];
  logic [16:0] prog_a[$], prog_b[$];
  logic        adv_a = 1'b1, adv_b = 1'b1;
  int          n_vec = 0, n_err = 0;

  function automatic logic [16:0] rand_instr(input int nregs);
    logic [15:0] ir;
    int          sel;
    ir  = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 3)      ir[15:12] = OPC_LM;
    else if (sel < 6) ir[15:12] = OPC_SM;
    sel = $urandom_range(0, 7);
    if (sel == 0) begin
      for (int i = 0; i < nregs; i++) ir[i] = 1'b0;
    end else if (sel == 1) begin
      for (int i = 0; i < nregs; i++) ir[i] = 1'b0;
      ir[$urandom_range(0, nregs - 1)] = 1'b1;
    end
    return {($urandom_range(0, 9) != 0), ir};
  endfunction

  function automatic logic [15:0] with_mask(input logic [15:0] ir, input int nregs, input int r);
    logic [15:0] m;
    m = 16'((1 << nregs) - 1);
    return (ir & ~m) | 16'(1 << r);
  endfunction

  // Reference: an LM/SM owes one micro-op per set mask bit, in ascending
  // order; q holds the indices still owed after the current cycle's one.
  task automatic model(input int d, input logic [15:0] ir, input logic v,
                       input logic rn, input logic st, input logic fl,
                       output exp_t e);
    int q[$];
    int bits[$];
    int nregs;
    int r;
    nregs = (d == 0) ? 8 : 4;
    if (d == 0) q = pend_a; else q = pend_b;
    e     = '0;
    e.pcw = 1'b1;
    if (!rn) begin
      q.delete();
    end else if (q.size() > 0) begin
      r     = q[0];
      e.busy = 1'b1;
      e.irl  = 1'b1;
      e.ra   = 3'(r);
      e.nir  = with_mask(ir, nregs, r);
      e.lx   = (q.size() == 1);
      e.pcw  = e.lx && !st;
      if (fl) q.delete();
      else if (!st) void'(q.pop_front());
    end else begin
      if (v && (ir[15:12] == OPC_LM || ir[15:12] == OPC_SM)) begin
        for (int i = 0; i < nregs; i++) if (ir[i]) bits.push_back(i);
        if (bits.size() > 0) begin
          r     = bits[0];
          e.irl = 1'b1;
          e.fm  = 1'b1;
          e.ra  = 3'(r);
          e.nir = with_mask(ir, nregs, r);
          e.lx  = (bits.size() == 1);
          e.pcw = e.lx && !st;
          if (!st && !fl)
            for (int i = 1; i < bits.size(); i++) q.push_back(bits[i]);
        end else begin
`ifdef LCA_MULTI_ZERO_MASK_NOP_EN
          e.irl = 1'b1;
          e.nir = NOP_IR;
          e.lx  = 1'b1;
`endif
          e.pcw = !st;
        end
      end else begin
        e.pcw = !st;
      end
    end
    if (d == 0) pend_a = q; else pend_b = q;
  endtask

  task automatic cycle(input logic rn, input logic st, input logic fl);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    if (adv_a) begin
      if (prog_a.size() > 0) {v_a, ir_a} = prog_a.pop_front();
      else {v_a, ir_a} = rand_instr(8);
    end
    if (adv_b) begin
      if (prog_b.size() > 0) {v_b, ir_b} = prog_b.pop_front();
      else {v_b, ir_b} = rand_instr(4);
    end
    reset    = rn;
    stall_in = st;
    flush    = fl;
    model(0, ir_a, v_a, rn, st, fl, ea);
    model(1, ir_b, v_b, rn, st, fl, eb);
    exp_a.push_back(ea);
    exp_b.push_back(eb);
    adv_a = ea.pcw || fl || !rn;
    adv_b = eb.pcw || fl || !rn;
  endtask

  task automatic check(input string nm, input exp_t e, input exp_t g);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got busy=%b pc_write=%b ir_load_mux=%b new_ir=%h first=%b reg_addr=%0d last=%b, expected busy=%b pc_write=%b ir_load_mux=%b new_ir=%h first=%b reg_addr=%0d last=%b",
               nm, $time, g.busy, g.pcw, g.irl, g.nir, g.fm, g.ra, g.lx,
               e.busy, e.pcw, e.irl, e.nir, e.fm, e.ra, e.lx);
    end
  endtask

  // Monitor: outputs are combinational, so the negedge sees the settled
  // response to the inputs driven just after the preceding posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("dut8", e, {busy_a, pcw_a, irl_a, nir_a, fm_a, ra_a, lx_a});
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("dut4", e, {busy_b, pcw_b, irl_b, nir_b, fm_b, 1'b0, ra_b, lx_b});
      end
    end
  end

  initial begin
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // Directed: A5 mask, single-bit SM, FF with stall, 0F with flush,
    // 0F with reset, zero mask; the 4-register unit starts with mask 1001.
    prog_a.push_back({1'b1, 16'h64A5});
    prog_a.push_back({1'b1, 16'h7280});
    prog_a.push_back({1'b1, 16'h60FF});
    prog_a.push_back({1'b1, 16'h600F});
    prog_a.push_back({1'b1, 16'h600F});
    prog_a.push_back({1'b1, 16'h6000});
    prog_b.push_back({1'b1, 16'h6009});
    prog_b.push_back({1'b1, 16'h7000});

    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 19) == 0));
    end

    repeat (3) @(negedge clk);
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0/0",
               exp_a.size(), exp_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
